encoder_frontend: RTL and testbench

//  Conditions one raw quadrature rotary encoder (pins enc_a/enc_b from io_in) into a clean

---
 rtl/rgb_mixer_pkg.sv | 33 +++
 rtl/debounce_sync.sv | 44 ++++
 rtl/encoder_frontend.sv | 88 ++++++++
 tb/tb_encoder_frontend.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_mixer_pkg.sv
// Shared RGB mixer definitions: quadrature codes, rotation helpers, default widths.
// Pure definitions; no latency and no flow control.
package rgb_mixer_pkg;

  localparam int DEFAULT_WIDTH           = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_t;

  function automatic quad_t cw_next(input quad_t q);
    case (q)
      Q00:     cw_next = Q01;
      Q01:     cw_next = Q11;
      Q11:     cw_next = Q10;
      default: cw_next = Q00;
    endcase
  endfunction

  function automatic quad_t ccw_next(input quad_t q);
    case (q)
      Q00:     ccw_next = Q10;
      Q10:     ccw_next = Q11;
      Q11:     ccw_next = Q01;
      default: ccw_next = Q00;
    endcase
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus vector debounce; deb follows din after CYCLES stable clocks.
// deb/deb_update change CYCLES+2 edges after a new level is first sampled; no backpressure.
module debounce_sync #(
  parameter int N      = 2,
  parameter int CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  output logic [N-1:0] deb,
  output logic         deb_update
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

  logic [N-1:0]     sync1;
  logic [N-1:0]     sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      deb_update <= 1'b0;
      cnt        <= '0;
    end else begin
      sync1      <= din;
      sync2      <= sync1;
      deb_update <= 1'b0;
      // sync1 != sync2 means the synchronized level is about to change
      if ((sync1 != sync2) || (sync2 == deb)) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(CYCLES - 1)) begin
        cnt        <= '0;
        deb        <= sync2;
        deb_update <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/encoder_frontend.sv
// Quadrature encoder front end: debounced x4 decode driving a saturating/wrapping level counter.
// value/inc/dec/err update one edge after each debounced level change; no backpressure.
module encoder_frontend
  import rgb_mixer_pkg::*;
#(
  parameter int          WIDTH           = DEFAULT_WIDTH,
  parameter int          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned STEP            = 1,
  parameter bit          SATURATE        = 1'b1,
  parameter int unsigned RESET_VALUE     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             inc,
  output logic             dec,
  output logic             err
);

  localparam logic [WIDTH:0]   STEP_X    = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] MAX_VALUE = '1;

  logic [1:0]     deb;
  logic           deb_update;
  logic [1:0]     prev;
  logic           primed;
  logic           step_cw;
  logic           step_ccw;
  logic           step_err;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH-1:0] value_next;

  debounce_sync #(
    .N      (2),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .din        ({enc_a, enc_b}),
    .deb        (deb),
    .deb_update (deb_update)
  );

  always_comb begin
    step_cw    = deb_update && primed && (quad_t'(deb) == cw_next(quad_t'(prev)));
    step_ccw   = deb_update && primed && (quad_t'(deb) == ccw_next(quad_t'(prev)));
    step_err   = deb_update && primed && !step_cw && !step_ccw;
    sum        = {1'b0, value} + STEP_X;
    diff       = {1'b0, value} - STEP_X;
    value_next = value;
    // The extra MSB flags overflow on sum and underflow on diff
    if (step_cw) begin
      value_next = (SATURATE && sum[WIDTH]) ? MAX_VALUE : sum[WIDTH-1:0];
    end else if (step_ccw) begin
      value_next = (SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
    end
    if (clear) begin
      value_next = RST_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value  <= RST_VAL;
      inc    <= 1'b0;
      dec    <= 1'b0;
      err    <= 1'b0;
      prev   <= '0;
      primed <= 1'b0;
    end else begin
      value <= value_next;
      inc   <= step_cw;
      dec   <= step_ccw;
      err   <= step_err;
      // The first debounced level after reset only establishes the reference
      if (deb_update) begin
        prev   <= deb;
        primed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_encoder_frontend.sv
// Directed bench for encoder_frontend: saturating and wrapping instances share stimulus,
// a run-length behavioural model is compared every cycle, plus hand-computed checkpoints.
module tb_encoder_frontend;

  localparam int D    = 16;
  localparam int STEP = 1;
  localparam int RV   = 0;
  localparam int HOLD = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_a;
  logic       enc_b;
  logic       clear;
  logic [7:0] val_s;
  logic [7:0] val_w;
  logic       inc_s, dec_s, err_s;
  logic       inc_w, dec_w, err_w;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int n_inc = 0;
  int n_dec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  encoder_frontend #(
    .WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(STEP), .SATURATE(1'b1), .RESET_VALUE(RV)
  ) dut_sat (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .value(val_s), .inc(inc_s), .dec(dec_s), .err(err_s)
  );

  encoder_frontend #(
    .WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(STEP), .SATURATE(1'b0), .RESET_VALUE(RV)
  ) dut_wrap (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .value(val_w), .inc(inc_w), .dec(dec_w), .err(err_w)
  );

  // Behavioural model: a level is accepted once the pins have been sampled identical
  // on D+1 consecutive edges; its effect appears on outputs two edges later.
  int         m_val_s, m_val_w, m_run;
  logic       m_inc, m_dec, m_err;
  logic [1:0] m_last, m_deb, m_prev;
  bit         m_primed;
  bit         q1_vld, q2_vld;
  logic [1:0] q1_v, q2_v;

  function automatic int qpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_edge();
    logic [1:0] raw;
    int d;
    m_inc = 1'b0;
    m_dec = 1'b0;
    m_err = 1'b0;
    if (reset) begin
      m_val_s = RV; m_val_w = RV;
      m_last = 2'b00; m_run = D + 1; m_deb = 2'b00; m_prev = 2'b00;
      m_primed = 1'b0; q1_vld = 1'b0; q2_vld = 1'b0;
    end else begin
      if (q2_vld) begin
        if (!m_primed) begin
          m_primed = 1'b1;
        end else begin
          d = (qpos(q2_v) - qpos(m_prev) + 4) % 4;
          if (d == 1) begin
            m_inc   = 1'b1;
            m_val_s = (m_val_s + STEP > 255) ? 255 : m_val_s + STEP;
            m_val_w = (m_val_w + STEP) % 256;
          end else if (d == 3) begin
            m_dec   = 1'b1;
            m_val_s = (m_val_s - STEP < 0) ? 0 : m_val_s - STEP;
            m_val_w = (m_val_w - STEP + 256) % 256;
          end else begin
            m_err = 1'b1;
          end
        end
        m_prev = q2_v;
      end
      if (clear) begin
        m_val_s = RV;
        m_val_w = RV;
      end
      q2_vld = q1_vld;
      q2_v   = q1_v;
      q1_vld = 1'b0;
      raw = {enc_a, enc_b};
      if (raw != m_last) begin
        m_last = raw;
        m_run  = 1;
      end else if (m_run <= D) begin
        m_run++;
      end
      if (m_run == D + 1 && raw != m_deb) begin
        m_deb  = raw;
        q1_vld = 1'b1;
        q1_v   = raw;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checks++;
      if (val_s !== 8'(m_val_s) || inc_s !== m_inc || dec_s !== m_dec || err_s !== m_err) begin
        errors++;
        $display("FAIL model_sat t=%0t got value=%0d inc=%b dec=%b err=%b want value=%0d inc=%b dec=%b err=%b",
                 $time, val_s, inc_s, dec_s, err_s, m_val_s, m_inc, m_dec, m_err);
      end
      checks++;
      if (val_w !== 8'(m_val_w) || inc_w !== m_inc || dec_w !== m_dec || err_w !== m_err) begin
        errors++;
        $display("FAIL model_wrap t=%0t got value=%0d inc=%b dec=%b err=%b want value=%0d inc=%b dec=%b err=%b",
                 $time, val_w, inc_w, dec_w, err_w, m_val_w, m_inc, m_dec, m_err);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (inc_s === 1'b1) n_inc++;
    if (dec_s === 1'b1) n_dec++;
    if (err_s === 1'b1) n_err++;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  logic [1:0] cw_seq [4];
  int idx;
  int b_inc, b_dec, b_err, hit;

  task automatic hold_level(input logic [1:0] v, input int n);
    {enc_a, enc_b} = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic step_cw();
    idx = (idx + 1) % 4;
    hold_level(cw_seq[idx], HOLD);
  endtask

  task automatic step_ccw();
    idx = (idx + 3) % 4;
    hold_level(cw_seq[idx], HOLD);
  endtask

  task automatic snap();
    b_inc = n_inc;
    b_dec = n_dec;
    b_err = n_err;
  endtask

  initial begin
    cw_seq[0] = 2'b00; cw_seq[1] = 2'b01; cw_seq[2] = 2'b11; cw_seq[3] = 2'b10;
    idx = 0;
    reset = 1'b1; clear = 1'b0; enc_a = 1'b0; enc_b = 1'b0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("reset_outputs_sat", {val_s, inc_s, dec_s, err_s}, 0);
    check("reset_outputs_wrap", {val_w, inc_w, dec_w, err_w}, 0);

    // Four full CW cycles; the first transition only primes
    snap();
    for (int i = 0; i < 16; i++) step_cw();
    repeat (4) @(negedge clk);
    check("cw16_value_sat", val_s, 15);
    check("cw16_value_wrap", val_w, 15);
    check("cw16_inc_count", n_inc - b_inc, 15);
    check("cw16_no_err", n_err - b_err, 0);

    // Clear to 0, climb to 3, then five CCW steps
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    check("clear_idle_value", val_s, 0);
    for (int i = 0; i < 3; i++) step_cw();
    check("climb_value", val_s, 3);
    snap();
    for (int i = 0; i < 5; i++) step_ccw();
    check("ccw_sat_value", val_s, 0);
    check("ccw_wrap_value", val_w, 254);
    check("ccw_dec_count", n_dec - b_dec, 5);

    // Move to 00, then jump to 11 with both pins at once
    step_cw();
    step_cw();
    snap();
    idx = 2;
    hold_level(2'b11, HOLD);
    check("jump_err_count", n_err - b_err, 1);
    check("jump_value_sat", val_s, 2);
    check("jump_value_wrap", val_w, 0);
    step_cw();
    check("after_jump_sat", val_s, 3);
    check("after_jump_wrap", val_w, 1);

    // Bounce on enc_a every 3 clocks, then settle on 00
    snap();
    for (int i = 0; i < 14; i++) begin
      enc_a = ~enc_a;
      repeat (3) @(negedge clk);
    end
    idx = 0;
    {enc_a, enc_b} = 2'b00;
    hit = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (inc_s === 1'b1 && hit == 0) hit = k;
    end
    check("bounce_latency", hit, 19);
    check("bounce_inc_count", n_inc - b_inc, 1);
    check("bounce_other_pulses", (n_dec - b_dec) + (n_err - b_err), 0);
    check("bounce_value_sat", val_s, 4);

    // Reach 100, then clear on the same edge as a CW step
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 100; i++) step_cw();
    check("hundred_value", val_s, 100);
    idx = (idx + 1) % 4;
    {enc_a, enc_b} = cw_seq[idx];
    repeat (18) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_step_inc", inc_s, 1);
    check("clear_step_value_sat", val_s, RV);
    check("clear_step_value_wrap", val_w, RV);
    repeat (HOLD - 19) @(negedge clk);
    step_cw();
    check("post_clear_step", val_s, RV + 1);

    // Reset ten clocks into a debounce window
    idx = (idx + 1) % 4;
    {enc_a, enc_b} = cw_seq[idx];
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    snap();
    repeat (30) @(negedge clk);
    check("reset_mid_no_pulse", (n_inc - b_inc) + (n_dec - b_dec) + (n_err - b_err), 0);
    check("reset_mid_value", val_s, RV);
    snap();
    step_cw();
    check("reset_next_inc", n_inc - b_inc, 1);
    check("reset_next_value", val_s, RV + 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
